// File: rtl/vfpu_operand_joiner_if.sv
// HWPE-style stream interface: one operand word per handshake.
//   valid  producer -> consumer, word present
//   ready  consumer -> producer, word accepted when valid & ready
//   data   DATA_WIDTH payload
//   strb   byte strobes, DATA_WIDTH/8 bits
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);
  modport master (output valid, data, strb, input ready);
  modport slave  (input valid, data, strb, output ready);
endinterface

// File: rtl/vfpu_operand_joiner.sv
// Operand joiner for the VFPU adder: buffers NB_OPERANDS independent operand
// streams in per-operand FIFOs and re-emits them as lock-stepped tuples.
//   clk_i, rst_i (async, active high), clear_i (sync soft clear)
//   operand_streams_sink[]   incoming operand streams
//   operand_streams_source[] aligned operand streams, common valid
//   start_i / len_i          job start and tuple count (sampled in IDLE)
//   busy_o, done_o, count_o  job status
module vfpu_operand_joiner #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NB_OPERANDS = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  hwpe_stream_intf_stream.sink          operand_streams_sink   [NB_OPERANDS],
  hwpe_stream_intf_stream.source        operand_streams_source [NB_OPERANDS],
  input  logic                          start_i,
  input  logic [15:0]                   len_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [15:0]                   count_o
);
  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned ENTRY_W = DATA_WIDTH + STRB_W;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       len_q;
  logic [NB_OPERANDS-1:0] fifo_empty;
  logic [NB_OPERANDS-1:0] sink_ready;
  logic [NB_OPERANDS-1:0] src_ready;
  logic                   all_valid;
  logic                   pop;
  logic                   start_ok;
  logic                   last;

  assign all_valid = &(~fifo_empty);
  assign pop       = all_valid & (&src_ready);
  assign start_ok  = (state_q == IDLE) & start_i;
  assign last      = (CNT_W'(count_q + CNT_W'(1)) == len_q);

  // Next-state and registered status decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (len_i == '0) ? DONE : RUN;
      RUN:     if (pop && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) state_d = IDLE;
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Job length and delivered-tuple counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q   <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      len_q   <= '0;
      count_q <= '0;
    end else if (start_ok) begin
      len_q   <= len_i;
      count_q <= '0;
    end else if (pop) begin
      count_q <= CNT_W'(count_q + CNT_W'(1));
    end
  end

  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign count_o = count_q;

  for (genvar g = 0; g < NB_OPERANDS; g++) begin : g_op
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]     wr_ptr;
    logic [PTR_W:0]     rd_ptr;
    logic [CNT_W-1:0]   in_cnt;
    logic [ENTRY_W-1:0] head;
    logic               full;
    logic               push;

    // Extra MSB distinguishes full from empty when the index bits match
    assign full = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign fifo_empty[g] = (wr_ptr == rd_ptr);

    // Ready only looks at local FIFO state, never at the source side
    assign sink_ready[g] = (state_q == RUN) & ~full & (in_cnt < len_q);
    assign operand_streams_sink[g].ready = sink_ready[g];
    assign push = operand_streams_sink[g].valid & sink_ready[g];

    assign src_ready[g] = operand_streams_source[g].ready;
    assign head = mem[rd_ptr[PTR_W-1:0]];
    assign operand_streams_source[g].valid = all_valid;
    assign operand_streams_source[g].data  = all_valid ? head[ENTRY_W-1:STRB_W] : '0;
    assign operand_streams_source[g].strb  = all_valid ? head[STRB_W-1:0] : '0;

    // Pointers and per-operand accepted-word counter
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        in_cnt <= '0;
      end else if (clear_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        in_cnt <= '0;
      end else begin
        if (start_ok) in_cnt <= '0;
        if (push) begin
          wr_ptr <= (PTR_W+1)'(wr_ptr + (PTR_W+1)'(1));
          in_cnt <= CNT_W'(in_cnt + CNT_W'(1));
        end
        if (pop) rd_ptr <= (PTR_W+1)'(rd_ptr + (PTR_W+1)'(1));
      end
    end

    // Storage needs no reset; the head is masked until valid
    always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr[PTR_W-1:0]] <= {operand_streams_sink[g].data,
                                           operand_streams_sink[g].strb};
    end
  end
endmodule

// File: tb/tb_vfpu_operand_joiner.sv
// Self-checking bench for vfpu_operand_joiner (2 operands, depth 4).
module tb_vfpu_operand_joiner;
  localparam int unsigned DW    = 32;
  localparam int unsigned NB    = 2;
  localparam int unsigned DEPTH = 4;

  typedef logic [35:0] word_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        start;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic [15:0] count;

  logic        sink_valid [NB];
  logic [31:0] sink_data  [NB];
  logic [3:0]  sink_strb  [NB];
  logic        sink_ready [NB];
  logic        src_valid  [NB];
  logic [31:0] src_data   [NB];
  logic [3:0]  src_strb   [NB];
  logic        src_ready  [NB];

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) sink_if [NB] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) src_if  [NB] ();

  for (genvar g = 0; g < NB; g++) begin : g_conn
    assign sink_if[g].valid = sink_valid[g];
    assign sink_if[g].data  = sink_data[g];
    assign sink_if[g].strb  = sink_strb[g];
    assign sink_ready[g]    = sink_if[g].ready;
    assign src_if[g].ready  = src_ready[g];
    assign src_valid[g]     = src_if[g].valid;
    assign src_data[g]      = src_if[g].data;
    assign src_strb[g]      = src_if[g].strb;
  end

  vfpu_operand_joiner #(
    .DATA_WIDTH (DW),
    .NB_OPERANDS(NB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .clear_i               (clear),
    .operand_streams_sink  (sink_if),
    .operand_streams_source(src_if),
    .start_i               (start),
    .len_i                 (len),
    .busy_o                (busy),
    .done_o                (done),
    .count_o               (count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int dut_done_cnt = 0;

  // Reference model: each FIFO is a queue of accepted-but-not-delivered words
  word_t mq   [NB][$];
  word_t plan [NB][$];
  word_t cur  [NB];
  bit    have [NB];
  int    m_acc [NB];
  int    m_len, m_count;
  bit    m_run, m_done;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_run = 1'b0; m_done = 1'b0; m_len = 0; m_count = 0;
    for (int i = 0; i < NB; i++) begin
      m_acc[i] = 0;
      mq[i].delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("%s_sink_ready[%0d]", tag, i), 36'(sink_ready[i]), 36'(0));
      chk($sformatf("%s_src_valid[%0d]", tag, i), 36'(src_valid[i]), 36'(0));
      chk($sformatf("%s_src_word[%0d]", tag, i), {src_data[i], src_strb[i]}, 36'(0));
    end
    chk({tag, "_busy"}, 36'(busy), 36'(0));
    chk({tag, "_done"}, 36'(done), 36'(0));
    chk({tag, "_count"}, 36'(count), 36'(0));
  endtask

  // One clock: drive at negedge, check against model, then advance model at posedge
  task automatic cycle(input logic [1:0] ven, input logic [1:0] rdy,
                       input logic st, input logic [15:0] ln, input logic clr);
    bit exp_rdy [NB];
    bit exp_v;
    bit pop;
    word_t exp_w;
    @(negedge clk);
    start = st; len = ln; clear = clr;
    for (int i = 0; i < NB; i++) begin
      if (ven[i] && !have[i]) begin
        if (plan[i].size() > 0) cur[i] = plan[i].pop_front();
        else cur[i] = {$urandom, 4'($urandom)};
        have[i] = 1'b1;
      end
      sink_valid[i] = ven[i];
      sink_data[i]  = ven[i] ? cur[i][35:4] : 32'h0;
      sink_strb[i]  = ven[i] ? cur[i][3:0] : 4'h0;
      src_ready[i]  = rdy[i];
    end
    #1;
    exp_v = (mq[0].size() > 0) && (mq[1].size() > 0);
    for (int i = 0; i < NB; i++) begin
      exp_rdy[i] = m_run && (mq[i].size() < DEPTH) && (m_acc[i] < m_len);
      exp_w = 36'(0);
      if (exp_v) exp_w = mq[i][0];
      chk($sformatf("sink_ready[%0d]", i), 36'(sink_ready[i]), 36'(exp_rdy[i]));
      chk($sformatf("src_valid[%0d]", i), 36'(src_valid[i]), 36'(exp_v));
      chk($sformatf("src_word[%0d]", i), {src_data[i], src_strb[i]}, exp_w);
    end
    chk("busy", 36'(busy), 36'(m_run));
    chk("done", 36'(done), 36'(m_done));
    chk("count", 36'(count), 36'(m_count));
    if (done) dut_done_cnt++;
    pop = exp_v && rdy[0] && rdy[1];
    @(posedge clk);
    if (clr) begin
      reset_model();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (!m_run && st) begin
      m_len = int'(ln); m_count = 0;
      for (int i = 0; i < NB; i++) m_acc[i] = 0;
      if (ln == 16'd0) m_done = 1'b1; else m_run = 1'b1;
    end else if (m_run) begin
      if (pop) begin
        for (int i = 0; i < NB; i++) void'(mq[i].pop_front());
        m_count++;
        if (m_count == m_len) begin m_run = 1'b0; m_done = 1'b1; end
      end
      for (int i = 0; i < NB; i++) begin
        if (ven[i] && exp_rdy[i]) begin
          mq[i].push_back(cur[i]);
          m_acc[i]++;
          have[i] = 1'b0;
        end
      end
    end
  endtask

  function automatic logic [1:0] rnd2(input int pct);
    rnd2 = {1'($urandom_range(99) < pct), 1'($urandom_range(99) < pct)};
  endfunction

  // Random-traffic job, bounded; checks exactly one done pulse
  task automatic run_job(input int ln, input int vp, input int rp, input int maxc);
    int d0 = dut_done_cnt;
    int n = 0;
    cycle(2'b00, 2'b11, 1'b1, 16'(ln), 1'b0);
    while ((m_run || m_done) && n < maxc) begin
      cycle(rnd2(vp), rnd2(rp), 1'b0, 16'd0, 1'b0);
      n++;
    end
    chk($sformatf("job_done_pulses_len%0d", ln), 36'(dut_done_cnt - d0), 36'(1));
    chk($sformatf("job_final_count_len%0d", ln), 36'(count), 36'(ln));
  endtask

  initial begin
    int d0;
    rst = 1'b1; clear = 1'b0; start = 1'b0; len = 16'd0;
    for (int i = 0; i < NB; i++) begin
      sink_valid[i] = 1'b0; sink_data[i] = '0; sink_strb[i] = '0;
      src_ready[i] = 1'b0; have[i] = 1'b0;
    end
    reset_model();
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Directed A/B stream, back-to-back, source always ready
    for (int k = 1; k <= 4; k++) begin
      plan[0].push_back({32'(k), 4'hF});
      plan[1].push_back({32'(k * 10), 4'hF});
    end
    d0 = dut_done_cnt;
    cycle(2'b00, 2'b11, 1'b1, 16'd4, 1'b0);
    for (int n = 0; n < 20 && (m_run || m_done); n++) cycle(2'b11, 2'b11, 1'b0, 16'd0, 1'b0);
    chk("ab_done_pulses", 36'(dut_done_cnt - d0), 36'(1));
    chk("ab_count", 36'(count), 36'(4));

    // Skew: operand 0 early, operand 1 from cycle 5
    d0 = dut_done_cnt;
    cycle(2'b00, 2'b11, 1'b1, 16'd3, 1'b0);
    for (int n = 0; n < 5; n++) cycle((n < 3) ? 2'b01 : 2'b00, 2'b11, 1'b0, 16'd0, 1'b0);
    for (int n = 0; n < 20 && (m_run || m_done); n++) cycle(2'b11, 2'b11, 1'b0, 16'd0, 1'b0);
    chk("skew_done_pulses", 36'(dut_done_cnt - d0), 36'(1));

    // Backpressure: 10 cycles of source stall on an 8-tuple job
    d0 = dut_done_cnt;
    cycle(2'b00, 2'b00, 1'b1, 16'd8, 1'b0);
    for (int n = 0; n < 10; n++) cycle(2'b11, 2'b00, 1'b0, 16'd0, 1'b0);
    for (int n = 0; n < 40 && (m_run || m_done); n++) cycle(2'b11, 2'b11, 1'b0, 16'd0, 1'b0);
    chk("bp_done_pulses", 36'(dut_done_cnt - d0), 36'(1));
    chk("bp_count", 36'(count), 36'(8));

    // Zero-length job
    d0 = dut_done_cnt;
    cycle(2'b00, 2'b11, 1'b1, 16'd0, 1'b0);
    cycle(2'b11, 2'b11, 1'b0, 16'd0, 1'b0);
    cycle(2'b11, 2'b11, 1'b0, 16'd0, 1'b0);
    chk("len0_done_pulses", 36'(dut_done_cnt - d0), 36'(1));

    // Overrun: sinks keep offering past the job length
    d0 = dut_done_cnt;
    cycle(2'b00, 2'b11, 1'b1, 16'd5, 1'b0);
    for (int n = 0; n < 30 && (m_run || m_done); n++) cycle(2'b11, rnd2(70), 1'b0, 16'd0, 1'b0);
    cycle(2'b11, 2'b11, 1'b0, 16'd0, 1'b0);
    chk("overrun_done_pulses", 36'(dut_done_cnt - d0), 36'(1));
    chk("overrun_count", 36'(count), 36'(5));

    // Soft clear mid-job with words buffered
    d0 = dut_done_cnt;
    cycle(2'b00, 2'b00, 1'b1, 16'd6, 1'b0);
    cycle(2'b11, 2'b00, 1'b0, 16'd0, 1'b0);
    cycle(2'b11, 2'b00, 1'b0, 16'd0, 1'b0);
    cycle(2'b11, 2'b11, 1'b1, 16'd3, 1'b1);
    cycle(2'b00, 2'b11, 1'b0, 16'd0, 1'b0);
    chk("clear_no_done", 36'(dut_done_cnt - d0), 36'(0));
    run_job(5, 80, 80, 100);

    // Randomized jobs
    for (int j = 0; j < 20; j++)
      run_job($urandom_range(1, 20), $urandom_range(30, 100), $urandom_range(30, 100), 400);

    // Asynchronous reset mid-job
    d0 = dut_done_cnt;
    cycle(2'b00, 2'b00, 1'b1, 16'd10, 1'b0);
    for (int n = 0; n < 3; n++) cycle(2'b11, 2'b00, 1'b0, 16'd0, 1'b0);
    @(negedge clk);
    for (int i = 0; i < NB; i++) sink_valid[i] = 1'b0;
    start = 1'b0;
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    reset_model();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_no_done", 36'(dut_done_cnt - d0), 36'(0));
    run_job(7, 90, 60, 200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
